// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
//  Module      : hilo_muldiv_unit
//  Description : Execute-stage multiply/divide unit owning the HI/LO registers.
//                Multi-cycle MULT/MULTU/DIV/DIVU with pipeline stall and
//                flush-driven cancellation; single-cycle MTHI/MTLO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv_unit #(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cancel_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int c_cntW = $clog2(WIDTH + 1);
   // Count value of the last MUL cycle (unused when MUL_LATENCY is 1)
   localparam logic [c_cntW-1:0] c_mulLast = c_cntW'((MUL_LATENCY >= 2) ? MUL_LATENCY - 2 : 0);
   localparam logic [c_cntW-1:0] c_divLast = c_cntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t r_state, w_nextState;

   logic [c_cntW-1:0]  r_count;
   logic [WIDTH-1:0]   r_mulA, r_mulB;
   logic               r_mulSigned;
   logic [WIDTH-1:0]   r_rem, r_quo, r_divisor;
   logic               r_negQuo, r_negRem, r_divZero;
   logic [WIDTH-1:0]   r_hi, r_lo;

   logic               w_accept, w_idle;
   logic               w_mulWrite, w_divWrite, w_hiWrite, w_loWrite;
   logic [WIDTH-1:0]   w_srcA, w_srcB;
   logic               w_srcSigned;
   logic [2*WIDTH-1:0] w_extA, w_extB, w_prod;
   logic               w_negA, w_negB;
   logic [WIDTH-1:0]   w_absA, w_absB;
   logic [WIDTH:0]     w_remShift, w_diff;
   logic               w_qBit;
   logic [WIDTH-1:0]   w_remNext, w_quoNext, w_quoFinal, w_remFinal;

   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = w_idle & start_i & ~cancel_i;

   // With MUL_LATENCY=1 the product is committed in the accept cycle, so the
   // multiplier reads the live operands while idle and the latched ones otherwise.
   assign w_srcA      = w_idle ? a_i : r_mulA;
   assign w_srcB      = w_idle ? b_i : r_mulB;
   assign w_srcSigned = w_idle ? ~op_i[0] : r_mulSigned;
   assign w_extA      = {{WIDTH{w_srcSigned & w_srcA[WIDTH-1]}}, w_srcA};
   assign w_extB      = {{WIDTH{w_srcSigned & w_srcB[WIDTH-1]}}, w_srcB};
   assign w_prod      = w_extA * w_extB;

   // Divide runs on magnitudes; signs are reapplied to the final quotient/remainder
   assign w_negA = ~op_i[0] & a_i[WIDTH-1];
   assign w_negB = ~op_i[0] & b_i[WIDTH-1];
   assign w_absA = w_negA ? -a_i : a_i;
   assign w_absB = w_negB ? -b_i : b_i;

   // One restoring step: shift in the next dividend bit, subtract if it fits
   assign w_remShift = {r_rem, r_quo[WIDTH-1]};
   assign w_diff     = w_remShift - {1'b0, r_divisor};
   assign w_qBit     = ~w_diff[WIDTH];
   assign w_remNext  = w_qBit ? w_diff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
   assign w_quoNext  = {r_quo[WIDTH-2:0], w_qBit};
   assign w_quoFinal = r_negQuo ? -w_quoNext : w_quoNext;
   assign w_remFinal = r_negRem ? -w_remNext : w_remNext;

   // Next-state selection and HI/LO write enables
   always_comb begin
      w_nextState = r_state;
      w_mulWrite  = 1'b0;
      w_divWrite  = 1'b0;
      w_hiWrite   = 1'b0;
      w_loWrite   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (op_i)
                  3'd0, 3'd1: begin
                     if (MUL_LATENCY == 1) begin
                        w_nextState = S_FIN;
                        w_mulWrite  = 1'b1;
                     end else begin
                        w_nextState = S_MUL;
                     end
                  end
                  3'd2, 3'd3: w_nextState = S_DIV;
                  3'd4:       w_hiWrite   = 1'b1;
                  3'd5:       w_loWrite   = 1'b1;
                  default:    w_nextState = S_IDLE;
               endcase
            end
         end
         S_MUL: begin
            if (cancel_i) begin
               w_nextState = S_IDLE;
            end else if (r_count == c_mulLast) begin
               w_nextState = S_FIN;
               w_mulWrite  = 1'b1;
            end
         end
         S_DIV: begin
            if (cancel_i) begin
               w_nextState = S_IDLE;
            end else if (r_count == c_divLast) begin
               w_nextState = S_FIN;
               w_divWrite  = ~r_divZero;
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nextState;
   end

   // Operand capture at accept and per-cycle iteration of MUL/DIV
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= '0;
         r_mulA      <= '0;
         r_mulB      <= '0;
         r_mulSigned <= 1'b0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_divisor   <= '0;
         r_negQuo    <= 1'b0;
         r_negRem    <= 1'b0;
         r_divZero   <= 1'b0;
      end else if (w_accept && !op_i[2]) begin
         r_count     <= '0;
         r_mulA      <= a_i;
         r_mulB      <= b_i;
         r_mulSigned <= ~op_i[0];
         r_rem       <= '0;
         r_quo       <= w_absA;
         r_divisor   <= w_absB;
         r_negQuo    <= w_negA ^ w_negB;
         r_negRem    <= w_negA;
         r_divZero   <= op_i[1] & (b_i == '0);
      end else if (r_state == S_MUL) begin
         r_count <= r_count + 1'b1;
      end else if (r_state == S_DIV) begin
         r_count <= r_count + 1'b1;
         r_rem   <= w_remNext;
         r_quo   <= w_quoNext;
      end
   end

   // Architectural HI/LO registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_mulWrite) begin
         r_hi <= w_prod[2*WIDTH-1:WIDTH];
         r_lo <= w_prod[WIDTH-1:0];
      end else if (w_divWrite) begin
         r_hi <= w_remFinal;
         r_lo <= w_quoFinal;
      end else begin
         if (w_hiWrite) r_hi <= a_i;
         if (w_loWrite) r_lo <= a_i;
      end
   end

   assign stall_o       = (w_accept & ~op_i[2]) |
                          (((r_state == S_MUL) | (r_state == S_DIV)) & ~cancel_i);
   assign busy_o        = ~w_idle;
   assign done_o        = (r_state == S_FIN);
   assign div_by_zero_o = done_o & r_divZero;
   assign hi_o          = r_hi;
   assign lo_o          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
//  Module      : tb_hilo_muldiv_unit
//  Description : Self-checking bench for hilo_muldiv_unit: transaction-level
//                reference model compared every cycle, directed scenarios with
//                literal expectations, then randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_unit;

   localparam int c_mulLat = 2;
   localparam int c_divLat = 33;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cancel = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        stall, busy, done, dbz;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;

   hilo_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(c_mulLat)) dut (
      .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .cancel_i(cancel), .stall_o(stall), .busy_o(busy), .done_o(done),
      .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of one operation from plain arithmetic
   function automatic void opResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] rh, output logic [31:0] rl, output bit dz);
      longint lx, ly;
      logic [63:0] p;
      int sx, sy;
      dz = 1'b0; rh = 32'd0; rl = 32'd0;
      case (o)
         3'd0: begin
            lx = longint'($signed(x)); ly = longint'($signed(y));
            p = 64'(lx * ly); rh = p[63:32]; rl = p[31:0];
         end
         3'd1: begin
            p = {32'd0, x} * {32'd0, y}; rh = p[63:32]; rl = p[31:0];
         end
         3'd2: begin
            if (y == 32'd0) dz = 1'b1;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = x; rh = 32'd0; end
            else begin sx = x; sy = y; rl = 32'(sx / sy); rh = 32'(sx % sy); end
         end
         default: begin
            if (y == 32'd0) dz = 1'b1;
            else begin rl = x / y; rh = x % y; end
         end
      endcase
   endfunction

   // Reference model state: visible HI/LO, cycles left to the done cycle, pending result
   logic [31:0] mHi = 32'd0, mLo = 32'd0, pHi = 32'd0, pLo = 32'd0;
   int          mLeft = 0;
   bit          mDone = 1'b0, mDbz = 1'b0, pDbz = 1'b0;

   task automatic commitPending();
      mDone = 1'b1;
      mDbz  = pDbz;
      if (!pDbz) begin mHi = pHi; mLo = pLo; end
   endtask

   // Advance the model on each edge, then compare every output mid-cycle
   initial begin
      bit expIdle, expStall;
      forever begin
         @(posedge clk);
         if (rst) begin
            mHi = 32'd0; mLo = 32'd0; mLeft = 0; mDone = 1'b0; mDbz = 1'b0;
         end else if (mDone) begin
            mDone = 1'b0; mDbz = 1'b0;
         end else if (mLeft > 0) begin
            if (cancel) mLeft = 0;
            else begin
               mLeft--;
               if (mLeft == 0) commitPending();
            end
         end else if (start && !cancel) begin
            if (op == 3'd4) mHi = a;
            else if (op == 3'd5) mLo = a;
            else if (op < 3'd4) begin
               opResult(op, a, b, pHi, pLo, pDbz);
               mLeft = (op < 3'd2) ? c_mulLat - 1 : c_divLat - 1;
               if (mLeft == 0) commitPending();
            end
         end
         @(negedge clk);
         expIdle  = (mLeft == 0) && !mDone;
         expStall = (expIdle && start && op < 3'd4 && !cancel) || (mLeft > 0 && !cancel);
         check("model stall_o", 32'(stall), 32'(expStall));
         check("model busy_o",  32'(busy),  32'(!expIdle));
         check("model done_o",  32'(done),  32'(mDone));
         check("model div_by_zero_o", 32'(dbz), 32'(mDone && mDbz));
         check("model hi_o", hi, mHi);
         check("model lo_o", lo, mLo);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request for one cycle, then scramble the operands
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      step();
      start = 1'b0; a = $urandom; b = $urandom;
   endtask

   // Called in cycle T+1; returns in the done cycle after checking latency
   task automatic waitDone(input string name, input int expLat);
      int lat = 1;
      while (!done && lat < 100) begin
         step();
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'(expLat));
   endtask

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 300));
         default: return $urandom;
      endcase
   endfunction

   // Directed scenarios followed by random traffic
   initial begin
      rst = 1'b1;
      step(); step();
      check("reset hi_o", hi, 32'd0);
      check("reset lo_o", lo, 32'd0);
      check("reset busy_o", 32'(busy), 32'd0);
      check("reset done_o", 32'(done), 32'd0);
      rst = 1'b0;
      step();

      issue(3'd2, 32'd7, 32'hFFFF_FFFE);
      waitDone("DIV 7/-2", 33);
      check("DIV 7/-2 lo_o", lo, 32'hFFFF_FFFD);
      check("DIV 7/-2 hi_o", hi, 32'h0000_0001);
      step();

      issue(3'd0, 32'hFFFF_FFFF, 32'd2);
      waitDone("MULT", 2);
      check("MULT hi_o", hi, 32'hFFFF_FFFF);
      check("MULT lo_o", lo, 32'hFFFF_FFFE);
      step();
      issue(3'd1, 32'hFFFF_FFFF, 32'd2);
      waitDone("MULTU", 2);
      check("MULTU hi_o", hi, 32'h0000_0001);
      check("MULTU lo_o", lo, 32'hFFFF_FFFE);
      step();

      issue(3'd4, 32'hA, 32'd0);
      issue(3'd5, 32'hB, 32'd0);
      issue(3'd3, 32'd5, 32'd0);
      waitDone("DIVU by zero", 33);
      check("DIVU by zero div_by_zero_o", 32'(dbz), 32'd1);
      check("DIVU by zero hi_o", hi, 32'hA);
      check("DIVU by zero lo_o", lo, 32'hB);
      step();

      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone("DIV overflow", 33);
      check("DIV overflow lo_o", lo, 32'h8000_0000);
      check("DIV overflow hi_o", hi, 32'h0000_0000);
      step();
      issue(3'd4, 32'h1234, 32'd0);
      check("MTHI hi_o", hi, 32'h1234);
      issue(3'd5, 32'h5678, 32'd0);
      check("MTLO lo_o", lo, 32'h5678);

      issue(3'd3, 32'd100, 32'd7);
      repeat (9) step();
      cancel = 1'b1;
      #1;
      check("cancel stall_o", 32'(stall), 32'd0);
      step();
      cancel = 1'b0;
      check("cancel busy_o", 32'(busy), 32'd0);
      issue(3'd3, 32'd100, 32'd7);
      waitDone("DIVU 100/7", 33);
      check("DIVU 100/7 lo_o", lo, 32'd14);
      check("DIVU 100/7 hi_o", hi, 32'd2);
      step();

      issue(3'd2, 32'd1234567, 32'd89);
      repeat (4) step();
      rst = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD;
      step();
      rst = 1'b0; start = 1'b0;
      check("mid-op reset hi_o", hi, 32'd0);
      check("mid-op reset lo_o", lo, 32'd0);
      check("mid-op reset busy_o", 32'(busy), 32'd0);
      check("mid-op reset done_o", 32'(done), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         start  = ($urandom_range(0, 3) == 0);
         op     = 3'($urandom_range(0, 7));
         a      = randOperand();
         b      = randOperand();
         cancel = ($urandom_range(0, 39) == 0);
         rst    = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0; start = 1'b0; cancel = 1'b0;
      repeat (40) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
